// File: rtl/pausible_clock_ctrl_mc.sv
// pausible_clock_ctrl_mc: divided local clock that pauses low for round-robin 4-phase requesters
module pausible_clock_ctrl_mc #(
  parameter int NCH = 2,
  parameter int HALF_PERIOD = 4,
  parameter int RESUME_DLY = 2,
  parameter int MIN_EDGES = 1,
  parameter int MAX_PAUSE = 64
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NCH-1:0] req,
  output logic [NCH-1:0] grant,
  output logic           clock_out,
  output logic           paused,
  output logic           err_timeout,
  input  logic           clr_err
);
  localparam int PW = NCH > 1 ? $clog2(NCH) : 1;
  localparam int DW = HALF_PERIOD > 1 ? $clog2(HALF_PERIOD) : 1;
  localparam int EW = $clog2(MIN_EDGES + 2);
  localparam int CW = $clog2(MAX_PAUSE + 2);
  localparam int RW = $clog2(RESUME_DLY + 2);
  typedef enum logic [1:0] {RUN, DRAIN, PAUSED, RESUME} state_t;
  state_t state, state_nx;
  logic [DW-1:0] div_cnt;
  logic [EW-1:0] edge_cnt;
  logic [CW-1:0] pause_cnt;
  logic [RW-1:0] res_cnt;
  logic [PW-1:0] rr_ptr, sel, win, off, pick;
  logic [NCH-1:0] rot, sh;
  logic running, tick, hold, eligible, sel_req, to_pause;
  int s;
  assign running = state == RUN || state == DRAIN;
  assign tick = running && div_cnt == DW'(HALF_PERIOD - 1);
  assign hold = !clock_out && !tick;
  assign eligible = |req && edge_cnt >= EW'(MIN_EDGES);
  assign sel_req = req[sel];
  assign paused = state == PAUSED;
  assign pick = state == RUN ? win : sel;
  // Rotate so the search starts at rr_ptr; descending scan leaves the nearest set bit
  always_comb begin
    rot = NCH'({req, req} >> rr_ptr);
    off = '0;
    sh = '0;
    for (int k = NCH - 1; k >= 0; k--) begin
      sh = rot >> k;
      off = sh[0] ? PW'(k) : off;
    end
    s = int'(rr_ptr) + int'(off);
    win = PW'(s >= NCH ? s - NCH : s);
  end
  always_comb begin
    state_nx = state;
    to_pause = 1'b0;
    case (state)
      RUN: if (eligible) begin
        to_pause = hold;
        state_nx = hold ? PAUSED : DRAIN;
      end
      DRAIN: if (!sel_req) state_nx = RUN;
        else if (hold) begin
          to_pause = 1'b1;
          state_nx = PAUSED;
        end
      PAUSED: if (!sel_req) state_nx = RESUME;
      default: if (int'(res_cnt) + 1 >= RESUME_DLY) state_nx = RUN;
    endcase
  end
  always_ff @(posedge clk) state <= rst ? RUN : state_nx;
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
      clock_out <= 1'b0;
      edge_cnt <= EW'(MIN_EDGES);
      pause_cnt <= '0;
      res_cnt <= '0;
      rr_ptr <= '0;
      sel <= '0;
      grant <= '0;
      err_timeout <= 1'b0;
    end else begin
      div_cnt <= tick ? '0 : running ? div_cnt + 1'b1 : state == RESUME ? '0 : div_cnt;
      if (tick) clock_out <= ~clock_out;
      if (tick && !clock_out && edge_cnt < EW'(MIN_EDGES)) edge_cnt <= edge_cnt + 1'b1;
      if (state == RUN && eligible) sel <= win;
      if (to_pause) grant <= NCH'(1) << pick;
      if (state == PAUSED && !sel_req) begin
        grant <= '0;
        rr_ptr <= int'(sel) == NCH - 1 ? '0 : sel + 1'b1;
        edge_cnt <= '0;
        pause_cnt <= '0;
      end else if (state == PAUSED && pause_cnt < CW'(MAX_PAUSE)) pause_cnt <= pause_cnt + 1'b1;
      res_cnt <= state == RESUME ? res_cnt + 1'b1 : '0;
      err_timeout <= (state == PAUSED && pause_cnt == CW'(MAX_PAUSE - 1)) ? 1'b1 : clr_err ? 1'b0 : err_timeout;
    end
  end
endmodule
